// File: rtl/aes_stream_pkg.sv
// Shared types for the AES word-stream stages (packer upstream, unpacker downstream).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: block/word widths, the block record carried between stages, packer state encoding.
package aes_stream_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_N      = AES_BLK_W / AES_WORD_W;
  localparam int AES_NW_W   = $clog2(AES_N) + 1;

  // One block as handed between stages: payload, valid-word count, message end.
  typedef struct packed {
    logic [AES_BLK_W-1:0] data;
    logic [AES_NW_W-1:0]  nwords;
    logic                 last;
  } aes_blk_t;

  // FILL: accumulating words. FULL: a finished block waits in the accumulator.
  typedef enum logic {
    PACK_FILL = 1'b0,
    PACK_FULL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/aes_word_packer_if.sv
// Word-in / block-out bundle of the AES word packer.
// Latency: n/a (wires only).
// Backpressure: word_valid_i/word_ready_o upstream, blk_valid_o/blk_ready_i downstream.
// Modports: slave = the packer itself, master = the side driving words and taking blocks.
interface aes_word_packer_if
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = AES_WORD_W,
  parameter int BLK_W  = AES_BLK_W
);
  localparam int N    = BLK_W / WORD_W;
  localparam int NW_W = $clog2(N) + 1;

  logic              clear_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic [WORD_W-1:0] word_i;
  logic              word_last_i;
  logic              blk_valid_o;
  logic              blk_ready_i;
  logic [BLK_W-1:0]  blk_o;
  logic [NW_W-1:0]   blk_nwords_o;
  logic              blk_last_o;

  modport slave (
    input  clear_i, word_valid_i, word_i, word_last_i, blk_ready_i,
    output word_ready_o, blk_valid_o, blk_o, blk_nwords_o, blk_last_o
  );

  modport master (
    output clear_i, word_valid_i, word_i, word_last_i, blk_ready_i,
    input  word_ready_o, blk_valid_o, blk_o, blk_nwords_o, blk_last_o
  );

endinterface

// File: rtl/aes_blk_slot.sv
// Single-entry valid/ready holding register for one block record.
// Latency: 1 cycle from in_vld_i accept to out_vld_o.
// Backpressure: in_rdy_o = empty or draining this cycle, so back-to-back loads need no bubble.
// Ports: clk_i/rst_i, clear_i flush, in_* load side, out_* drain side.
module aes_blk_slot
  import aes_stream_pkg::*;
#(
  parameter type T = aes_blk_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic in_vld_i,
  output logic in_rdy_o,
  input  T     in_dat_i,
  output logic out_vld_o,
  input  logic out_rdy_i,
  output T     out_dat_o
);

  logic vld_q, vld_d;
  T     dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear_i) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/aes_word_packer.sv
// Packs a word stream into blocks (word 0 in the MSBs), zero-padding short final blocks.
// Latency: block valid on the edge accepting its final word, or one cycle after the output frees.
// Backpressure: word_ready_o drops only while a finished block waits behind a held output.
// Ports: clk_i, rst_i (async, active-high), bus = aes_word_packer_if.slave.
module aes_word_packer
  import aes_stream_pkg::*;
#(
  parameter int WORD_W = AES_WORD_W,
  parameter int BLK_W  = AES_BLK_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  aes_word_packer_if.slave  bus
);

  localparam int N     = BLK_W / WORD_W;
  localparam int CNT_W = $clog2(N);
  localparam int NW_W  = $clog2(N) + 1;

  typedef struct packed {
    logic [BLK_W-1:0] data;
    logic [NW_W-1:0]  nwords;
    logic             last;
  } blk_t;

  pack_state_e                  state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [N-2:0][WORD_W-1:0]     slot_q, slot_d;
  blk_t                         acc_q, acc_d;

  logic [BLK_W-1:0] blk_data;
  blk_t             new_blk;
  logic             accept, complete, last_slot;
  logic             out_vld, out_rdy;
  blk_t             out_in_dat, out_dat;
  logic             out_out_vld;

  // Candidate block: stored slots above cnt, incoming word at cnt, zeros below.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (CNT_W'(i) < cnt_q) blk_data[BLK_W-1-i*WORD_W -: WORD_W] = slot_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) == cnt_q) blk_data[BLK_W-1-i*WORD_W -: WORD_W] = bus.word_i;
    end
  end

  assign last_slot      = (cnt_q == CNT_W'(N - 1));
  assign accept         = bus.word_valid_i && (state_q == PACK_FILL) && !bus.clear_i;
  assign complete       = accept && (last_slot || bus.word_last_i);
  assign new_blk.data   = blk_data;
  assign new_blk.nwords = NW_W'(cnt_q) + NW_W'(1);
  assign new_blk.last   = bus.word_last_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    acc_d      = acc_q;
    out_vld    = 1'b0;
    out_in_dat = new_blk;
    if (bus.clear_i) begin
      state_d = PACK_FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PACK_FILL: begin
          if (complete) begin
            // out_rdy already covers "output empty or draining", i.e. bypass.
            if (out_rdy) begin
              out_vld = 1'b1;
            end else begin
              acc_d   = new_blk;
              state_d = PACK_FULL;
            end
            cnt_d = '0;
          end else if (accept) begin
            slot_d[cnt_q] = bus.word_i;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end
        PACK_FULL: begin
          if (out_rdy) begin
            out_vld    = 1'b1;
            out_in_dat = acc_q;
            state_d    = PACK_FILL;
            cnt_d      = '0;
          end
        end
        default: state_d = PACK_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PACK_FILL;
      cnt_q   <= '0;
      slot_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      acc_q   <= acc_d;
    end
  end

  aes_blk_slot #(.T(blk_t)) u_out (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (bus.clear_i),
    .in_vld_i (out_vld),
    .in_rdy_o (out_rdy),
    .in_dat_i (out_in_dat),
    .out_vld_o(out_out_vld),
    .out_rdy_i(bus.blk_ready_i),
    .out_dat_o(out_dat)
  );

  assign bus.word_ready_o = (state_q == PACK_FILL);
  assign bus.blk_valid_o  = out_out_vld;
  assign bus.blk_o        = out_dat.data;
  assign bus.blk_nwords_o = out_dat.nwords;
  assign bus.blk_last_o   = out_dat.last;

endmodule

// File: tb/tb_aes_word_packer.sv
// Bench for aes_word_packer: directed vectors plus randomized traffic against a block model.
// Latency: n/a.
// Backpressure: blk_ready_i driven directed or randomly per cycle.
module tb_aes_word_packer;
  import aes_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_word_packer_if bus ();

  aes_word_packer dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [127:0] data;
    int           nw;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  part_q[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           n_blk = 0;
  int           stall_cnt = 0;
  bit           rnd_rdy = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // Model: collect accepted words; a block closes at 4 words or on last, MSB word first.
  initial begin : monitor
    logic [127:0] d;
    exp_t         e;
    bit           hold;
    logic [127:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.clear_i) begin
        exp_q.delete();
        part_q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_vld", bus.blk_valid_o, 1);
          check("hold_dat", bus.blk_o, held);
        end
        if (bus.blk_valid_o && bus.blk_ready_i) begin
          n_blk++;
          check("blk_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("blk_dat", bus.blk_o, e.data);
            check("blk_nw", bus.blk_nwords_o, e.nw);
            check("blk_last", bus.blk_last_o, e.last);
          end
        end
        hold = bus.blk_valid_o && !bus.blk_ready_i;
        held = bus.blk_o;
        if (bus.word_valid_i && bus.word_ready_o) begin
          part_q.push_back(bus.word_i);
          if (part_q.size() == 4 || bus.word_last_i) begin
            d = '0;
            for (int i = 0; i < part_q.size(); i++) d[127-32*i -: 32] = part_q[i];
            e.data = d;
            e.nw   = part_q.size();
            e.last = bus.word_last_i;
            exp_q.push_back(e);
            part_q.delete();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.blk_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [31:0] w, input bit l);
    bit rdy;
    int k;
    k = 0;
    bus.word_valid_i = 1'b1;
    bus.word_i       = w;
    bus.word_last_i  = l;
    do begin
      @(negedge clk);
      rdy = bus.word_ready_o;
      if (!rdy) stall_cnt++;
      tick();
      k++;
    end while (!rdy && k < 200);
    if (!rdy) check("push_timeout", rdy, 1);
  endtask

  task automatic idle(input int n);
    bus.word_valid_i = 1'b0;
    bus.word_last_i  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_vld"}, bus.blk_valid_o, 0);
    check({tag, "_dat"}, bus.blk_o, 0);
    check({tag, "_nw"}, bus.blk_nwords_o, 0);
    check({tag, "_last"}, bus.blk_last_o, 0);
    check({tag, "_rdy"}, bus.word_ready_o, 1);
  endtask

  initial begin : main
    logic [31:0] w [8];
    int          nb0;
    rst              = 1'b1;
    bus.clear_i      = 1'b0;
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    bus.word_last_i  = 1'b0;
    bus.blk_ready_i  = 1'b1;
    #12;
    chk_reset_outs("rst0");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // FIPS-197 plaintext, back-to-back, last on the 4th word.
    push(32'h3243f6a8, 0);
    push(32'h885a308d, 0);
    push(32'h313198a2, 0);
    push(32'he0370734, 1);
    check("fips_vld", bus.blk_valid_o, 1);
    check("fips_dat", bus.blk_o, 128'h3243f6a8885a308d313198a2e0370734);
    check("fips_nw", bus.blk_nwords_o, 4);
    check("fips_last", bus.blk_last_o, 1);

    // Short final block: zero padded.
    push(32'hdeadbeef, 0);
    push(32'h01234567, 1);
    check("part_dat", bus.blk_o, 128'hdeadbeef012345670000000000000000);
    check("part_nw", bus.blk_nwords_o, 2);
    check("part_last", bus.blk_last_o, 1);
    idle(2);

    // Last on the first word.
    push(32'hcafef00d, 1);
    check("one_dat", bus.blk_o, 128'hcafef00d000000000000000000000000);
    check("one_nw", bus.blk_nwords_o, 1);
    idle(2);

    // Backpressure: two blocks buffered, then drained in order.
    bus.blk_ready_i = 1'b0;
    foreach (w[i]) w[i] = $urandom;
    foreach (w[i]) push(w[i], 0);
    check("bp_rdy", bus.word_ready_o, 0);
    check("bp_vld", bus.blk_valid_o, 1);
    check("bp_blk1", bus.blk_o, {w[0], w[1], w[2], w[3]});
    bus.word_valid_i = 1'b0;
    bus.blk_ready_i  = 1'b1;
    tick();
    check("bp_blk2", bus.blk_o, {w[4], w[5], w[6], w[7]});
    check("bp_vld2", bus.blk_valid_o, 1);
    check("bp_resume", bus.word_ready_o, 1);
    tick();
    check("bp_empty", bus.blk_valid_o, 0);

    // Streaming: 40 words, no stalls, 10 blocks.
    nb0       = n_blk;
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) push($urandom, 0);
    idle(2);
    check("stream_blocks", n_blk - nb0, 10);
    check("stream_stall", stall_cnt, 0);

    // Clear after 2 words, with a word presented during the clear.
    push($urandom, 0);
    push($urandom, 0);
    bus.clear_i      = 1'b1;
    bus.word_valid_i = 1'b1;
    bus.word_i       = $urandom;
    tick();
    bus.clear_i      = 1'b0;
    bus.word_valid_i = 1'b0;
    check("clr_vld", bus.blk_valid_o, 0);
    check("clr_rdy", bus.word_ready_o, 1);
    foreach (w[i]) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push(w[i], 0);
    check("clr_dat", bus.blk_o, {w[0], w[1], w[2], w[3]});
    check("clr_nw", bus.blk_nwords_o, 4);
    idle(2);

    // Clear while FULL.
    bus.blk_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push($urandom, 0);
    check("clrf_full", bus.word_ready_o, 0);
    bus.word_valid_i = 1'b0;
    bus.clear_i      = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check("clrf_vld", bus.blk_valid_o, 0);
    check("clrf_rdy", bus.word_ready_o, 1);
    bus.blk_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(w[i+4], i == 3);
    check("clrf_dat", bus.blk_o, {w[4], w[5], w[6], w[7]});
    check("clrf_last", bus.blk_last_o, 1);
    idle(2);

    // Asynchronous reset mid-block with a held output.
    bus.blk_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push($urandom, 0);
    bus.word_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("rst1");
    @(posedge clk);
    #1 rst = 1'b0;
    bus.blk_ready_i = 1'b1;
    foreach (w[i]) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push(w[i], 0);
    check("rst_post_dat", bus.blk_o, {w[0], w[1], w[2], w[3]});
    check("rst_post_nw", bus.blk_nwords_o, 4);
    idle(2);

    // Randomized traffic: random gaps, random last, random downstream ready.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push($urandom, $urandom_range(0, 5) == 0);
      idle($urandom_range(0, 2));
    end
    push($urandom, 1);
    rnd_rdy         = 1'b0;
    bus.blk_ready_i = 1'b1;
    idle(4);
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_idle", bus.blk_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
